// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the single-cycle
// writeback (primary) and a FIFO-buffered multi-cycle writeback (secondary).
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          p_valid,
    input  logic [ADDR_WIDTH-1:0]         p_addr,
    input  logic [DATA_WIDTH-1:0]         p_data,
    output logic                          p_ready,
    input  logic                          s_valid,
    input  logic [ADDR_WIDTH-1:0]         s_addr,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          s_ready,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [ADDR_WIDTH-1:0]         q1_addr,
    input  logic [ADDR_WIDTH-1:0]         q2_addr,
    output logic                          q1_pend,
    output logic                          q2_pend,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MAX_WAIT);

    logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]    count_reg, count_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;

    logic                  fifo_nonempty;
    logic                  force_grant;
    logic                  grant_p;
    logic                  grant_s;
    logic                  enq;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    assign fifo_count    = count_reg;
    assign s_ready       = (count_reg != FULL_COUNT);
    assign fifo_nonempty = (count_reg != '0);
    assign force_grant   = fifo_nonempty && (wait_cnt_reg == WAIT_MAX);
    assign p_ready       = !force_grant;
    assign grant_p       = p_valid && !force_grant;
    assign grant_s       = fifo_nonempty && !grant_p;
    // Writes to register 0 are acknowledged but never stored.
    assign enq           = s_valid && s_ready && (s_addr != '0);
    assign head_addr     = addr_mem[rd_ptr_reg];
    assign head_data     = data_mem[rd_ptr_reg];

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        wait_cnt_next = wait_cnt_reg;

        if (enq) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (grant_s) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end

        case ({enq, grant_s})
            2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
            2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
            default: count_next = count_reg;
        endcase

        // Only cycles where a queued head loses to the primary count as denied.
        if (!fifo_nonempty || grant_s) begin
            wait_cnt_next = '0;
        end else if (grant_p && (wait_cnt_reg != WAIT_MAX)) begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr_reg] <= s_addr;
            data_mem[wr_ptr_reg] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            wait_cnt_reg <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            wait_cnt_reg <= wait_cnt_next;
            if (grant_p) begin
                wr_en   <= (p_addr != '0);
                wr_addr <= p_addr;
                wr_data <= p_data;
            end else if (grant_s) begin
                wr_en   <= (head_addr != '0);
                wr_addr <= head_addr;
                wr_data <= head_data;
            end else begin
                wr_en   <= 1'b0;
            end
        end
    end

    // Pending lookup: any occupied FIFO slot (head included) or the write in flight.
    logic [FIFO_DEPTH-1:0] entry_valid;
    logic [FIFO_DEPTH-1:0] q1_hit;
    logic [FIFO_DEPTH-1:0] q2_hit;

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] offset;
            assign offset          = PTR_W'(gi) - rd_ptr_reg;
            assign entry_valid[gi] = ({1'b0, offset} < count_reg);
            assign q1_hit[gi]      = entry_valid[gi] && (addr_mem[gi] == q1_addr);
            assign q2_hit[gi]      = entry_valid[gi] && (addr_mem[gi] == q2_addr);
        end
    endgenerate

    assign q1_pend = (q1_addr != '0) && ((|q1_hit) || (wr_en && (wr_addr == q1_addr)));
    assign q2_pend = (q2_addr != '0) && ((|q2_hit) || (wr_en && (wr_addr == q2_addr)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected register writes are queued
// as stimulus is driven and retired against the write port each cycle.
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          p_valid;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    logic          p_ready;
    logic          s_valid;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] q1_addr;
    logic [AW-1:0] q2_addr;
    logic          q1_pend;
    logic          q2_pend;
    logic [2:0]    fifo_count;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    regfile_write_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .FIFO_DEPTH(4),
        .MAX_WAIT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .p_valid(p_valid),
        .p_addr(p_addr),
        .p_data(p_data),
        .p_ready(p_ready),
        .s_valid(s_valid),
        .s_addr(s_addr),
        .s_data(s_data),
        .s_ready(s_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .q1_addr(q1_addr),
        .q2_addr(q2_addr),
        .q1_pend(q1_pend),
        .q2_pend(q2_pend),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Advance one edge, then retire any write the port produced.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
                failures++;
                $error("FAIL unexpected_write observed addr=%0h data=%0h expected no write",
                       wr_addr, wr_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_wr_addr", 64'(wr_addr), 64'(e.addr));
                chk("sb_wr_data", 64'(wr_data), 64'(e.data));
                $display("write addr=%0d data=%08h", wr_addr, wr_data);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        p_valid = 1'b0; p_addr = '0; p_data = '0;
        s_valid = 1'b0; s_addr = '0; s_data = '0;
        q1_addr = '0;   q2_addr = '0;
        #1;
        chk("reset_wr_en", 64'(wr_en), 64'd0);
        chk("reset_wr_addr", 64'(wr_addr), 64'd0);
        chk("reset_wr_data", 64'(wr_data), 64'd0);
        chk("reset_fifo_count", 64'(fifo_count), 64'd0);
        chk("reset_s_ready", 64'(s_ready), 64'd1);
        chk("reset_p_ready", 64'(p_ready), 64'd1);
        tick();
        tick();
        rst = 1'b0;

        // Primary only, including a write to register 0.
        p_valid = 1'b1; p_addr = 5'd7; p_data = 32'hDEADBEEF;
        #1;
        chk("prim_p_ready", 64'(p_ready), 64'd1);
        push(5'd7, 32'hDEADBEEF);
        tick();
        chk("prim_wr_en", 64'(wr_en), 64'd1);
        chk("prim_wr_addr", 64'(wr_addr), 64'd7);
        chk("prim_wr_data", 64'(wr_data), 64'hDEADBEEF);
        p_addr = 5'd0; p_data = 32'h1234;
        #1;
        chk("prim_r0_p_ready", 64'(p_ready), 64'd1);
        tick();
        chk("prim_r0_wr_en", 64'(wr_en), 64'd0);
        p_valid = 1'b0;
        tick();

        // Secondary through an idle port.
        s_valid = 1'b1; s_addr = 5'd9; s_data = 32'h55; q1_addr = 5'd9; q2_addr = 5'd10;
        #1;
        chk("sec_s_ready", 64'(s_ready), 64'd1);
        chk("sec_q1_pend_before", 64'(q1_pend), 64'd0);
        tick();
        s_valid = 1'b0;
        #1;
        chk("sec_fifo_count_1", 64'(fifo_count), 64'd1);
        chk("sec_q1_pend_queued", 64'(q1_pend), 64'd1);
        chk("sec_q2_pend_other", 64'(q2_pend), 64'd0);
        chk("sec_no_bypass", 64'(wr_en), 64'd0);
        push(5'd9, 32'h55);
        tick();
        chk("sec_wr_en", 64'(wr_en), 64'd1);
        chk("sec_fifo_count_0", 64'(fifo_count), 64'd0);
        chk("sec_q1_pend_inflight", 64'(q1_pend), 64'd1);
        tick();
        chk("sec_wr_en_off", 64'(wr_en), 64'd0);
        chk("sec_q1_pend_done", 64'(q1_pend), 64'd0);

        // Reset mid-operation with three queued entries and a write in flight.
        for (int k = 0; k < 3; k++) begin
            p_valid = 1'b1; p_addr = AW'(k + 1); p_data = 32'h100 + DW'(k);
            s_valid = 1'b1; s_addr = AW'(8 + k); s_data = 32'h800 + DW'(k);
            push(AW'(k + 1), 32'h100 + DW'(k));
            tick();
        end
        s_valid = 1'b0; q1_addr = 5'd8;
        #1;
        chk("mid_fifo_count_3", 64'(fifo_count), 64'd3);
        chk("mid_wr_en", 64'(wr_en), 64'd1);
        chk("mid_q1_pend", 64'(q1_pend), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
        chk("mid_rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_q1_pend", 64'(q1_pend), 64'd0);
        p_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_post_s_ready", 64'(s_ready), 64'd1);
        tick();
        chk("mid_post_wr_en", 64'(wr_en), 64'd0);
        chk("mid_post_fifo_count", 64'(fifo_count), 64'd0);

        // Starvation guard: primary wins three times, then the queued entry is forced.
        q1_addr = '0; q2_addr = 5'd3;
        for (int k = 0; k < 4; k++) begin
            p_valid = 1'b1; p_addr = AW'(10 + k); p_data = 32'hA000 + DW'(k);
            s_valid = (k == 0); s_addr = 5'd3; s_data = 32'hAAA;
            #1;
            chk("starve_p_ready", 64'(p_ready), 64'd1);
            push(AW'(10 + k), 32'hA000 + DW'(k));
            tick();
            if (k == 0) chk("starve_q2_pend", 64'(q2_pend), 64'd1);
        end
        s_valid = 1'b0; p_addr = 5'd14; p_data = 32'hA004;
        #1;
        chk("starve_forced_p_ready", 64'(p_ready), 64'd0);
        push(5'd3, 32'hAAA);
        tick();
        chk("starve_forced_wr_addr", 64'(wr_addr), 64'd3);
        chk("starve_fifo_empty", 64'(fifo_count), 64'd0);
        chk("starve_resume_p_ready", 64'(p_ready), 64'd1);
        push(5'd14, 32'hA004);
        tick();
        chk("starve_resume_wr_data", 64'(wr_data), 64'hA004);
        p_valid = 1'b0;
        tick();
        chk("starve_q2_pend_done", 64'(q2_pend), 64'd0);

        // FIFO full under continuous primary traffic; fifth request is dropped.
        q2_addr = '0;
        for (int k = 0; k < 4; k++) begin
            p_valid = 1'b1; p_addr = AW'(16 + k); p_data = 32'hB000 + DW'(k);
            s_valid = 1'b1; s_addr = AW'(24 + k); s_data = 32'hC000 + DW'(k);
            #1;
            chk("full_fill_s_ready", 64'(s_ready), 64'd1);
            push(AW'(16 + k), 32'hB000 + DW'(k));
            tick();
        end
        p_addr = 5'd20; p_data = 32'hB004;
        s_addr = 5'd28; s_data = 32'hC004;
        #1;
        chk("full_fifo_count_4", 64'(fifo_count), 64'd4);
        chk("full_s_ready", 64'(s_ready), 64'd0);
        chk("full_forced_p_ready", 64'(p_ready), 64'd0);
        push(5'd24, 32'hC000);
        tick();
        s_valid = 1'b0;
        #1;
        chk("full_drain_count_3", 64'(fifo_count), 64'd3);
        chk("full_drain_s_ready", 64'(s_ready), 64'd1);
        chk("full_drain_p_ready", 64'(p_ready), 64'd1);
        push(5'd20, 32'hB004);
        tick();
        p_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            push(AW'(24 + k), 32'hC000 + DW'(k));
            tick();
        end
        chk("full_drained_count", 64'(fifo_count), 64'd0);
        tick();
        chk("full_idle_wr_en", 64'(wr_en), 64'd0);

        // Secondary write to register 0 is accepted and discarded.
        s_valid = 1'b1; s_addr = 5'd0; s_data = 32'h77; q1_addr = 5'd0;
        #1;
        chk("r0_s_ready", 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0;
        #1;
        chk("r0_fifo_count", 64'(fifo_count), 64'd0);
        chk("r0_q1_pend", 64'(q1_pend), 64'd0);
        tick();
        chk("r0_wr_en", 64'(wr_en), 64'd0);
        tick();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
